add_tc_pipe: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with valid/ready flow control. It is the successor to the fixed 16/16 two's-complement adder. Width and pipeline depth are generic, and subtraction is selectable per operation. Backpressure is supported, so it can sit between streaming producers and consumers in the arithmetic datapath. Each stage resolves a WIDTH/STAGES-bit chunk of the carry chain, so the critical path scales with chunk size rather than full width.

---
 rtl/add_tc_pipe.sv | 157 +++++++++++++++
 tb/tb_add_tc_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_tc_pipe.sv
// add_tc_pipe: pipelined two's-complement adder/subtractor with valid/ready
// flow control. Each of the STAGES stages resolves one CHUNK = WIDTH/STAGES
// slice of the carry chain; the last stage also produces the sign bit.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     operand beat handshake (in_ready is combinational)
//   a, b                    signed WIDTH-bit operands
//   sub                     0: a+b, 1: a-b, captured with the beat
//   out_valid / out_ready   result beat handshake
//   sum                     exact signed WIDTH+1-bit result
//   ovf                     result does not fit in WIDTH signed bits
//
// Optional feature: define ADD_TC_PIPE_OVF_EN to add the ovf port and logic.
module add_tc_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
`ifdef ADD_TC_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CHUNK = WIDTH / STAGES;

  // Per-stage registers: valid, operands (b already conditionally inverted),
  // partially resolved sum and the carry out of the resolved chunk.
  logic [STAGES-1:0]            v_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q;
  logic [STAGES-1:0][WIDTH-1:0] b_q;
  logic [STAGES-1:0][WIDTH:0]   s_q;
  logic [STAGES-1:0]            c_q;

  logic [STAGES-1:0]            v_d;
  logic [STAGES-1:0][WIDTH:0]   s_d;
  logic [STAGES-1:0]            c_d;
  logic [STAGES-1:0]            load;
  logic [STAGES-1:0]            en;

  // Stage inputs: index 0 is the operand port, index k+1 is stage k's register.
  logic [STAGES:0][WIDTH-1:0]   src_a;
  logic [STAGES:0][WIDTH-1:0]   src_b;
  logic [STAGES:0][WIDTH:0]     src_s;
  logic [STAGES:0]              src_c;
  logic [STAGES:0]              src_v;

  logic                         acc;
  logic [CHUNK:0]               part;

  // Ready chain, evaluated from the output backwards so bubbles collapse.
  always_comb begin : p_ready
    load = '0;
    acc  = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      load[k] = !v_q[k] || acc;
      acc     = load[k];
    end
  end

  // Chunk adders: stage k adds its slice using the carry from stage k-1.
  always_comb begin : p_datapath
    src_a    = '0;
    src_b    = '0;
    src_s    = '0;
    src_c    = '0;
    src_v    = '0;
    s_d      = '0;
    c_d      = '0;
    v_d      = v_q;
    en       = '0;
    part     = '0;

    // Subtraction is a + ~b + 1; the +1 rides in as the stage-0 carry.
    src_a[0] = a;
    src_b[0] = sub ? ~b : b;
    src_c[0] = sub;
    src_v[0] = in_valid;
    for (int k = 0; k < int'(STAGES); k++) begin
      src_a[k+1] = a_q[k];
      src_b[k+1] = b_q[k];
      src_s[k+1] = s_q[k];
      src_c[k+1] = c_q[k];
      src_v[k+1] = v_q[k];
    end

    for (int k = 0; k < int'(STAGES); k++) begin
      part = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
           + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
           + (CHUNK+1)'(src_c[k]);
      s_d[k] = src_s[k];
      s_d[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      c_d[k] = part[CHUNK];
      // Sign bit of the sign-extended sum: both extension bits plus final carry.
      if (k == int'(STAGES) - 1) begin
        s_d[k][WIDTH] = src_a[k][WIDTH-1] ^ src_b[k][WIDTH-1] ^ part[CHUNK];
      end
      en[k]  = load[k] && src_v[k];
      v_d[k] = load[k] ? src_v[k] : v_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_regs
    if (!rst_n) begin
      v_q <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      c_q <= '0;
    end else begin
      v_q <= v_d;
      for (int k = 0; k < int'(STAGES); k++) begin
        if (en[k]) begin
          a_q[k] <= src_a[k];
          b_q[k] <= src_b[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];

`ifdef ADD_TC_PIPE_OVF_EN
  logic ovf_q;
  logic ovf_d;

  // Overflow: the exact sign bit disagrees with the WIDTH-bit sign bit.
  always_comb begin : p_ovf
    ovf_d = s_d[STAGES-1][WIDTH] ^ s_d[STAGES-1][WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_ovf_reg
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (en[STAGES-1]) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_add_tc_pipe.sv
// Self-checking bench for add_tc_pipe (WIDTH=32, STAGES=4). Results are
// checked against integer arithmetic on sign-extended operands; ovf checks
// are present when ADD_TC_PIPE_OVF_EN is defined.
module tb_add_tc_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] sum;
`ifdef ADD_TC_PIPE_OVF_EN
  logic        ovf;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_rcv    = 0;

  logic [32:0] exp_q[$];
  logic        exp_ovf_q[$];

  add_tc_pipe #(.WIDTH(32), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum)
`ifdef ADD_TC_PIPE_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic longint exact(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint xs, ys;
    xs = longint'($signed(x));
    ys = longint'($signed(y));
    return s ? (xs - ys) : (xs + ys);
  endfunction

  function automatic logic [32:0] model_sum(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint r;
    r = exact(x, y, s);
    return r[32:0];
  endfunction

  function automatic logic model_ovf(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint r;
    r = exact(x, y, s);
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: evaluate both handshakes just before the edge.
  task automatic tick();
    logic hs_in, hs_out;
    logic [32:0] e;
    logic eo;
    #1;
    hs_in  = in_valid && in_ready;
    hs_out = out_valid && out_ready;
    if (hs_out) begin
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        eo = exp_ovf_q.pop_front();
        check("stream_sum", 64'(sum), 64'(e));
`ifdef ADD_TC_PIPE_OVF_EN
        check("stream_ovf", 64'(ovf), 64'(eo));
`endif
      end
      n_rcv++;
    end
    if (hs_in) begin
      exp_q.push_back(model_sum(a, b, sub));
      exp_ovf_q.push_back(model_ovf(a, b, sub));
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_beat();
    a   = $urandom;
    b   = $urandom;
    sub = 1'($urandom_range(1, 0));
  endtask

  // Stream n random beats; mode 0: out_ready toggles, 1: random, 2: always 1.
  task automatic stream(input int n, input int mode, output int cycles);
    int acc0, rcv0, last_acc;
    acc0     = n_acc;
    rcv0     = n_rcv;
    last_acc = -1;
    cycles   = 0;
    while ((n_rcv - rcv0) < n && cycles < 500) begin
      case (mode)
        0:       out_ready = cycles[0];
        1:       out_ready = 1'($urandom_range(1, 0));
        default: out_ready = 1'b1;
      endcase
      in_valid = (n_acc - acc0) < n;
      if (n_acc != last_acc) randomize_beat();
      last_acc = n_acc;
      tick();
      cycles++;
    end
    in_valid = 1'b0;
    check("stream_rcv_count", 64'(n_rcv - rcv0), 64'(n));
    check("stream_acc_count", 64'(n_acc - acc0), 64'(n));
  endtask

  task automatic single(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                        input logic xs, input logic [32:0] es, input logic eo);
    int n;
    a = xa; b = xb; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd4);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_sum"}, 64'(sum), 64'(es));
`ifdef ADD_TC_PIPE_OVF_EN
    check({tag, "_ovf"}, 64'(ovf), 64'(eo));
`else
    if (eo === 1'bx) $display("note: unknown overflow expectation for %s", tag);
`endif
    @(posedge clk); #1;
    check({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin : main
    int cycles, acc0, stale;
    logic [32:0] held_sum;
    logic held_valid;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
`ifdef ADD_TC_PIPE_OVF_EN
    check("rst_ovf", 64'(ovf), 64'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed boundary beats
    single("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000, 1'b1);
    single("neg_ext", 32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000, 1'b1);
    single("sub_small", 32'd5, 32'd7, 1'b1, 33'h1_FFFF_FFFE, 1'b0);
    single("sub_min", 32'h8000_0000, 32'h0000_0001, 1'b1, 33'h1_7FFF_FFFF, 1'b1);

    // Streaming with backpressure
    stream(10, 0, cycles);
    stream(20, 1, cycles);

    // Full throughput: 8 beats back-to-back, last result leaves on cycle 12
    stream(8, 2, cycles);
    check("throughput_cycles", 64'(cycles), 64'd12);

    // Full stall
    acc0 = n_acc;
    out_ready = 1'b0;
    in_valid = 1'b1;
    held_valid = 1'b0;
    held_sum = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0 || n_acc != acc0 + i) randomize_beat();
      tick();
      if (out_valid) begin
        if (held_valid) check("stall_hold_sum", 64'(sum), 64'(held_sum));
        held_sum = sum;
        held_valid = 1'b1;
      end
    end
    #1;
    check("stall_accepted", 64'(n_acc - acc0), 64'd4);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    in_valid = 1'b0;
    #1;
    check("release_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 64'(out_valid), 64'd1);
      tick();
    end
    check("drain_empty", 64'(out_valid), 64'd0);
    check("drain_sb_empty", 64'(exp_q.size()), 64'd0);

    // Reset with three beats in flight
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_beat();
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sum", 64'(sum), 64'd0);
`ifdef ADD_TC_PIPE_OVF_EN
    check("mid_rst_ovf", 64'(ovf), 64'd0);
`endif
    exp_q.delete();
    exp_ovf_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) stale++;
      tick();
    end
    check("post_rst_no_stale", 64'(stale), 64'd0);

    // Traffic still flows correctly after the reset
    stream(6, 1, cycles);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
